ex_operand_stage: RTL and testbench
===================================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter DATA_W, default 32: operand, immediate and result width; the ALU it feeds is fixed at 32.
REQ-002 Parameter FWD_EN, default 1: 1 enables MEM/WB forwarding; 0 passes registered register-file values unchanged.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
REQ-004 ID-side inputs, captured on accepted edges:
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_data_i, id_rt_data_i, id_imm_i  in  DATA_W each  register-file reads; sign-extended immediate.
- id_rs_addr_i, id_rt_addr_i, id_rd_addr_i  in  5 each  source/destination register numbers.
- id_alu_ctrl_i  in  3  ALU op: 010 add, 110 sub, 001 or, 000 and, 100 mul.
- id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i  in  1 each  decoded controls.
REQ-005 Forwarding sources:
- mem_regwrite_i  in  1, mem_rd_addr_i  in  5, mem_result_i  in  DATA_W  EX/MEM producer.
- wb_regwrite_i  in  1, wb_rd_addr_i  in  5, wb_result_i  in  DATA_W  MEM/WB producer.
REQ-006 Pipeline control inputs:
- stall_i  in  1  hold all state.
- flush_i  in  1  kill the instruction entering EX.
REQ-007 Outputs:
- data1_o, data2_o  out  DATA_W  ALU operands.
- alu_ctrl_o  out  3  ALU op.
- store_data_o  out  DATA_W  forwarded rt value for stores.
- rd_addr_o  out  5  destination register.
- regwrite_o, memread_o, memwrite_o  out  1  controls, gated by valid.
- valid_o  out  1  EX holds a real instruction.
- load_use_o  out  1  load-use hazard; ID/IF must hold while it is asserted.

Function
REQ-008 Registered state: valid, rs/rt data, imm, rs/rt/rd addresses, alu_ctrl, alusrc, regwrite, memread, memwrite.
REQ-009 Per-edge priority: flush_i > stall_i > load_use_o > normal capture.
REQ-010 flush_i=1: valid and all controls cleared to 0; data and address registers don't-care; flush_i beats a simultaneous stall_i.
REQ-011 stall_i=1 with flush_i=0: every register holds its value.
REQ-012 load_use_o=1 with no flush or stall: a bubble is inserted (valid and controls 0); ID values are not consumed.
REQ-013 Otherwise: all ID inputs are captured; valid <= id_valid_i.
REQ-014 load_use_o is combinational; it equals valid & memread & (rd!=0) & id_valid_i & (rd==id_rs_addr_i | rd==id_rt_addr_i), using registered EX rd, valid and memread.
REQ-015 Forwarded rs value A (combinational, FWD_EN=1):
- mem_result_i if mem_regwrite_i & mem_rd_addr_i!=0 & mem_rd_addr_i==rs_addr;
- else wb_result_i if wb_regwrite_i & wb_rd_addr_i!=0 & wb_rd_addr_i==rs_addr;
- else registered rs data.
REQ-016 Forwarded rt value B uses the same rule with rt_addr; MEM always beats WB.
REQ-017 Register 0 is never forwarded.
REQ-018 data1_o=A; data2_o = imm if alusrc else B; store_data_o=B.
REQ-019 alu_ctrl_o and rd_addr_o are driven directly from their registers.
REQ-020 regwrite_o, memread_o and memwrite_o equal registered control AND valid.
REQ-021 Latency: an instruction accepted at edge N appears on outputs after edge N; operands reflect forwarding inputs in the same cycle.
REQ-022 No arithmetic is performed; widths pass through unchanged.

Reset
REQ-023 rst_i low SHALL asynchronously clear all registers to 0, independent of clk_i.
REQ-024 While in reset: valid_o, regwrite_o, memread_o, memwrite_o and load_use_o are 0; alu_ctrl_o=000; rd_addr_o=0; data1_o, data2_o and store_data_o are 0 when forwarding inputs are inactive.
REQ-025 Reset asserted mid-stall or mid-bubble discards the held instruction; the first capture after release takes ID inputs normally.

Verification
REQ-026 Plain capture: add r3=r1+r2 with rs_data=5, rt_data=7 -> next cycle data1_o=5, data2_o=7, alu_ctrl_o=010, valid_o=1, regwrite_o=1.
REQ-027 Double hazard: EX rs=r4; mem_rd=4 with result 0x11 and wb_rd=4 with result 0x22, both regwrite=1 -> data1_o=0x11. Repeat with mem_regwrite_i=0 -> data1_o=0x22. Repeat with rs=r0 -> registered value.
REQ-028 Load-use: lw r8 in EX, ID instruction uses rt=r8 -> load_use_o=1; next cycle valid_o=0, memread_o=0; the following cycle the ID instruction is captured with load_use_o=0.
REQ-029 Stall and flush: stall_i=1 for 3 cycles -> outputs unchanged. stall_i=1 and flush_i=1 together -> next cycle valid_o=0, regwrite_o=0, memwrite_o=0.
REQ-030 Immediate select: alusrc=1, imm=0xFFFFFFFC, rt forwarded 0x9 -> data2_o=0xFFFFFFFC, store_data_o=0x9.
REQ-031 Async reset: assert rst_i low between clock edges while valid_o=1 -> valid_o=0 and all controls 0 immediately, without a clock edge.

Source files
------------

// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: ID, forwarding, pipeline-control and EX-output signals of the operand stage
interface ex_operand_stage_if #(
    parameter int DATA_W = 32
);
    logic              id_valid_i;
    logic [DATA_W-1:0] id_rs_data_i;
    logic [DATA_W-1:0] id_rt_data_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [4:0]        id_rs_addr_i;
    logic [4:0]        id_rt_addr_i;
    logic [4:0]        id_rd_addr_i;
    logic [2:0]        id_alu_ctrl_i;
    logic              id_alusrc_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              id_memwrite_i;
    logic              mem_regwrite_i;
    logic [4:0]        mem_rd_addr_i;
    logic [DATA_W-1:0] mem_result_i;
    logic              wb_regwrite_i;
    logic [4:0]        wb_rd_addr_i;
    logic [DATA_W-1:0] wb_result_i;
    logic              stall_i;
    logic              flush_i;
    logic [DATA_W-1:0] data1_o;
    logic [DATA_W-1:0] data2_o;
    logic [2:0]        alu_ctrl_o;
    logic [DATA_W-1:0] store_data_o;
    logic [4:0]        rd_addr_o;
    logic              regwrite_o;
    logic              memread_o;
    logic              memwrite_o;
    logic              valid_o;
    logic              load_use_o;

    modport master (
        output id_valid_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_addr_i, id_rt_addr_i, id_rd_addr_i, id_alu_ctrl_i,
               id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i,
               mem_regwrite_i, mem_rd_addr_i, mem_result_i,
               wb_regwrite_i, wb_rd_addr_i, wb_result_i, stall_i, flush_i,
        input  data1_o, data2_o, alu_ctrl_o, store_data_o, rd_addr_o,
               regwrite_o, memread_o, memwrite_o, valid_o, load_use_o
    );

    modport slave (
        input  id_valid_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_addr_i, id_rt_addr_i, id_rd_addr_i, id_alu_ctrl_i,
               id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i,
               mem_regwrite_i, mem_rd_addr_i, mem_result_i,
               wb_regwrite_i, wb_rd_addr_i, wb_result_i, stall_i, flush_i,
        output data1_o, data2_o, alu_ctrl_o, store_data_o, rd_addr_o,
               regwrite_o, memread_o, memwrite_o, valid_o, load_use_o
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with MEM/WB operand forwarding and load-use detection
module ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter bit FWD_EN = 1'b1
) (
    input logic clk_i,
    input logic rst_i,
    ex_operand_stage_if.slave bus
);
    logic              valid, alusrc, regwrite, memread, memwrite;
    logic [DATA_W-1:0] rs_data, rt_data, imm;
    logic [4:0]        rs_addr, rt_addr, rd_addr;
    logic [2:0]        alu_ctrl;
    logic              load_use, mem_a, mem_b, wb_a, wb_b;
    logic [DATA_W-1:0] fwd_a, fwd_b;

    // Load in EX whose destination is read by the instruction waiting in ID
    always_comb begin
        load_use = valid & memread & (rd_addr != 5'd0) & bus.id_valid_i &
                   ((rd_addr == bus.id_rs_addr_i) | (rd_addr == bus.id_rt_addr_i));
    end

    // Operand forwarding: the younger MEM producer wins over WB; r0 is never forwarded
    always_comb begin
        mem_a = FWD_EN & bus.mem_regwrite_i & (bus.mem_rd_addr_i != 5'd0) & (bus.mem_rd_addr_i == rs_addr);
        mem_b = FWD_EN & bus.mem_regwrite_i & (bus.mem_rd_addr_i != 5'd0) & (bus.mem_rd_addr_i == rt_addr);
        wb_a  = FWD_EN & bus.wb_regwrite_i & (bus.wb_rd_addr_i != 5'd0) & (bus.wb_rd_addr_i == rs_addr);
        wb_b  = FWD_EN & bus.wb_regwrite_i & (bus.wb_rd_addr_i != 5'd0) & (bus.wb_rd_addr_i == rt_addr);
        fwd_a = mem_a ? bus.mem_result_i : wb_a ? bus.wb_result_i : rs_data;
        fwd_b = mem_b ? bus.mem_result_i : wb_b ? bus.wb_result_i : rt_data;
    end

    // Output drive; controls are qualified by valid so bubbles never write anything
    always_comb begin
        bus.data1_o      = fwd_a;
        bus.data2_o      = alusrc ? imm : fwd_b;
        bus.store_data_o = fwd_b;
        bus.alu_ctrl_o   = alu_ctrl;
        bus.rd_addr_o    = rd_addr;
        bus.regwrite_o   = regwrite & valid;
        bus.memread_o    = memread & valid;
        bus.memwrite_o   = memwrite & valid;
        bus.valid_o      = valid;
        bus.load_use_o   = load_use;
    end

    // ID/EX register: flush beats stall, stall beats load-use bubble, else capture ID
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid    <= 1'b0;
            alusrc   <= 1'b0;
            regwrite <= 1'b0;
            memread  <= 1'b0;
            memwrite <= 1'b0;
            alu_ctrl <= 3'd0;
            rs_data  <= '0;
            rt_data  <= '0;
            imm      <= '0;
            rs_addr  <= 5'd0;
            rt_addr  <= 5'd0;
            rd_addr  <= 5'd0;
        end else if (bus.flush_i || (!bus.stall_i && load_use)) begin
            valid    <= 1'b0;
            alusrc   <= 1'b0;
            regwrite <= 1'b0;
            memread  <= 1'b0;
            memwrite <= 1'b0;
            alu_ctrl <= 3'd0;
        end else if (!bus.stall_i) begin
            valid    <= bus.id_valid_i;
            alusrc   <= bus.id_alusrc_i;
            regwrite <= bus.id_regwrite_i;
            memread  <= bus.id_memread_i;
            memwrite <= bus.id_memwrite_i;
            alu_ctrl <= bus.id_alu_ctrl_i;
            rs_data  <= bus.id_rs_data_i;
            rt_data  <= bus.id_rt_data_i;
            imm      <= bus.id_imm_i;
            rs_addr  <= bus.id_rs_addr_i;
            rt_addr  <= bus.id_rt_addr_i;
            rd_addr  <= bus.id_rd_addr_i;
        end
    end
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: scoreboard-driven scenario bench for the EX operand stage
module tb_ex_operand_stage;
    typedef struct packed {
        logic        v, rw, mr, mw, lu;
        logic [2:0]  alu;
        logic [4:0]  rd;
        logic [31:0] d1, d2, sd;
    } out_t;

    typedef struct {
        out_t  e;
        out_t  m;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    out_t all_m, ctl_m;

    always #5 clk = ~clk;

    ex_operand_stage_if #(.DATA_W(32)) bus ();

    ex_operand_stage #(.DATA_W(32), .FWD_EN(1'b1)) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    function automatic out_t mk(input logic v, rw, mr, mw, lu, input logic [2:0] alu,
                                input logic [4:0] rd, input logic [31:0] d1, d2, sd);
        out_t o;
        o = '{v: v, rw: rw, mr: mr, mw: mw, lu: lu, alu: alu, rd: rd, d1: d1, d2: d2, sd: sd};
        return o;
    endfunction

    function automatic out_t sample();
        return mk(bus.valid_o, bus.regwrite_o, bus.memread_o, bus.memwrite_o, bus.load_use_o,
                  bus.alu_ctrl_o, bus.rd_addr_o, bus.data1_o, bus.data2_o, bus.store_data_o);
    endfunction

    task automatic push(input string name, input out_t e, input out_t m);
        exp_t x;
        x.e = e;
        x.m = m;
        x.name = name;
        q.push_back(x);
    endtask

    task automatic id_drive(input logic v, input logic [4:0] rs, rt, rd,
                            input logic [31:0] rsd, rtd, imm, input logic [2:0] alu,
                            input logic src, rw, mr, mw);
        bus.id_valid_i    = v;
        bus.id_rs_addr_i  = rs;
        bus.id_rt_addr_i  = rt;
        bus.id_rd_addr_i  = rd;
        bus.id_rs_data_i  = rsd;
        bus.id_rt_data_i  = rtd;
        bus.id_imm_i      = imm;
        bus.id_alu_ctrl_i = alu;
        bus.id_alusrc_i   = src;
        bus.id_regwrite_i = rw;
        bus.id_memread_i  = mr;
        bus.id_memwrite_i = mw;
    endtask

    task automatic fwd(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                       input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
        bus.mem_regwrite_i = mrw;
        bus.mem_rd_addr_i  = mrd;
        bus.mem_result_i   = mres;
        bus.wb_regwrite_i  = wrw;
        bus.wb_rd_addr_i   = wrd;
        bus.wb_result_i    = wres;
    endtask

    task automatic test_reset();
        exp_t sb;
        out_t o;
        id_drive(1'b1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1);
        fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        push("reset_state", mk(0, 0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0), all_m);
        @(posedge clk);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        #3 rst_n = 1'b1;
    endtask

    task automatic test_capture();
        exp_t sb;
        out_t o;
        id_drive(1'b1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
        push("plain_capture", mk(1, 1, 0, 0, 0, 3'b010, 5'd3, 32'h5, 32'h7, 32'h7), all_m);
        @(posedge clk);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
    endtask

    task automatic test_forward();
        exp_t sb;
        out_t o;
        id_drive(1'b1, 5'd4, 5'd5, 5'd6, 32'hAA, 32'hBB, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
        push("fwd_mem_beats_wb", mk(1, 1, 0, 0, 0, 3'b010, 5'd6, 32'h11, 32'hBB, 32'hBB), all_m);
        @(posedge clk);
        #1;
        fwd(1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        push("fwd_wb_only", mk(1, 1, 0, 0, 0, 3'b010, 5'd6, 32'h22, 32'hBB, 32'hBB), all_m);
        fwd(1'b0, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        push("fwd_rt_from_wb", mk(1, 1, 0, 0, 0, 3'b010, 5'd6, 32'h11, 32'h44, 32'h44), all_m);
        fwd(1'b1, 5'd4, 32'h11, 1'b1, 5'd5, 32'h44);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        id_drive(1'b1, 5'd0, 5'd0, 5'd6, 32'h33, 32'h34, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
        push("fwd_r0_blocked", mk(1, 1, 0, 0, 0, 3'b010, 5'd6, 32'h33, 32'h34, 32'h34), all_m);
        @(posedge clk);
        #1;
        fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_load_use();
        exp_t sb;
        out_t o;
        id_drive(1'b1, 5'd1, 5'd8, 5'd8, 32'h100, 32'h200, 32'h4, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        id_drive(1'b1, 5'd2, 5'd8, 5'd9, 32'h10, 32'h20, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
        push("load_use_detect", mk(1, 1, 1, 0, 1, 3'b010, 5'd8, 32'h100, 32'h4, 32'h200), all_m);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        push("load_use_bubble", mk(0, 0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0), ctl_m);
        @(posedge clk);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        push("load_use_replay", mk(1, 1, 0, 0, 0, 3'b010, 5'd9, 32'h10, 32'h20, 32'h20), all_m);
        @(posedge clk);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
    endtask

    task automatic test_stall_flush();
        exp_t sb;
        out_t o;
        id_drive(1'b1, 5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 32'h0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        push("stall_setup", mk(1, 0, 0, 1, 0, 3'b001, 5'd3, 32'h55, 32'h66, 32'h66), all_m);
        @(posedge clk);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        id_drive(1'b1, 5'd10, 5'd11, 5'd12, 32'h77, 32'h88, 32'h99, 3'b110, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("stall_hold", mk(1, 0, 0, 1, 0, 3'b001, 5'd3, 32'h55, 32'h66, 32'h66), all_m);
            @(posedge clk);
            #1;
            sb = q.pop_front(); o = sample(); checks++;
            if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        end
        bus.flush_i = 1'b1;
        push("flush_beats_stall", mk(0, 0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0), ctl_m);
        @(posedge clk);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    task automatic test_imm();
        exp_t sb;
        out_t o;
        id_drive(1'b1, 5'd0, 5'd7, 5'd0, 32'h3, 32'h1, 32'hFFFF_FFFC, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);
        push("imm_select", mk(1, 0, 0, 1, 0, 3'b010, 5'd0, 32'h3, 32'hFFFF_FFFC, 32'h9), all_m);
        @(posedge clk);
        #1;
        fwd(1'b1, 5'd7, 32'h9, 1'b0, 5'd0, 32'h0);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_async_reset();
        exp_t sb;
        out_t o;
        id_drive(1'b1, 5'd1, 5'd2, 5'd5, 32'h12, 32'h34, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1);
        push("async_setup", mk(1, 1, 1, 1, 0, 3'b010, 5'd5, 32'h12, 32'h34, 32'h34), all_m);
        @(posedge clk);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        bus.stall_i = 1'b1;
        #3 rst_n = 1'b0;
        push("async_reset_clear", mk(0, 0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0), all_m);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
        #2 rst_n = 1'b1;
        bus.stall_i = 1'b0;
        id_drive(1'b1, 5'd3, 5'd4, 5'd6, 32'h56, 32'h78, 32'h0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0);
        push("capture_after_reset", mk(1, 1, 0, 0, 0, 3'b100, 5'd6, 32'h56, 32'h78, 32'h78), all_m);
        @(posedge clk);
        #1;
        sb = q.pop_front(); o = sample(); checks++;
        if ((o & sb.m) !== (sb.e & sb.m)) begin errors++; $display("FAIL %s: got %h want %h", sb.name, o & sb.m, sb.e & sb.m); end
    endtask

    initial begin
        all_m = '1;
        ctl_m = '0;
        ctl_m.v = 1'b1;
        ctl_m.rw = 1'b1;
        ctl_m.mr = 1'b1;
        ctl_m.mw = 1'b1;
        ctl_m.lu = 1'b1;
        test_reset();
        test_capture();
        test_forward();
        test_load_use();
        test_stall_flush();
        test_imm();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
